// File: rtl/paint_pkg.sv
// Shared types for the brush painter: FSM states, the queued brush event and
// default framebuffer geometry.
package paint_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PAINT
    } state_t;

    typedef struct packed {
        logic [1:0] r;
        logic [2:0] color;
        logic [7:0] x;
        logic [7:0] y;
    } brush_evt_t;

    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 120;

endpackage

// File: rtl/event_fifo.sv
// Small synchronous FIFO of brush events. Read data is taken straight from the
// head slot, so the popped entry is visible in the same cycle as pop.
module event_fifo
    import paint_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       push,
    input  brush_evt_t push_data,
    input  logic       pop,
    output brush_evt_t pop_data,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);

    brush_evt_t       mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign do_pop   = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/brush_painter.sv
// Turns decoded brush/config commands into clipped square stamps of framebuffer
// writes, issued one pixel per arbiter grant.
module brush_painter
    import paint_pkg::*;
#(
    parameter int          WIDTH      = FB_WIDTH,
    parameter int          HEIGHT     = FB_HEIGHT,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [2:0]  COLOR_RST  = 3'd7,
    localparam int         ADDR_W     = $clog2(WIDTH*HEIGHT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              brushUpdate,
    input  logic [7:0]        x,
    input  logic [7:0]        y,
    input  logic [2:0]        newColorUpdate,
    input  logic              updateConfig,
    input  logic              fbGrant,
    output logic              fbWe,
    output logic [ADDR_W-1:0] fbAddr,
    output logic [2:0]        fbData,
    output logic              busy,
    output logic              overflow
);

    localparam logic [7:0]        X_LIM = 8'(WIDTH);
    localparam logic [7:0]        Y_LIM = 8'(HEIGHT);
    localparam logic signed [9:0] X_MAX = 10'(WIDTH - 1);
    localparam logic signed [9:0] Y_MAX = 10'(HEIGHT - 1);

    state_t            state_reg, state_next;
    logic              brush_q_reg, config_q_reg;
    logic              brush_edge, config_edge;
    logic [2:0]        color_reg;
    logic [1:0]        size_reg;
    logic              overflow_reg;
    brush_evt_t        evt_in, fifo_head, entry_reg;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [7:0]        px_reg, py_reg, px0_reg, px1_reg, py1_reg;
    logic [ADDR_W-1:0] row_base_reg;

    logic signed [9:0] cx, cy, rr, lo_x, hi_x, lo_y, hi_y;
    logic [7:0]        px0_c, px1_c, py0_c, py1_c;
    logic              entry_ok;
    logic [ADDR_W-1:0] row_part [8];
    logic [ADDR_W-1:0] row_base_c;

    assign brush_edge  = brushUpdate & ~brush_q_reg;
    assign config_edge = updateConfig & ~config_q_reg;

    // A config edge in the same cycle as a brush edge already applies to that event.
    always_comb begin
        evt_in.r     = config_edge ? x[1:0] : size_reg;
        evt_in.color = config_edge ? newColorUpdate : color_reg;
        evt_in.x     = x;
        evt_in.y     = y;
    end

    assign fifo_pop  = (state_reg == IDLE) & ~fifo_empty;
    assign fifo_push = brush_edge & (~fifo_full | fifo_pop);

    event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .srst     (reset),
        .push     (fifo_push),
        .push_data(evt_in),
        .pop      (fifo_pop),
        .pop_data (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Clipped stamp bounds from the popped entry, evaluated while in SETUP.
    always_comb begin
        cx       = signed'({2'b00, entry_reg.x});
        cy       = signed'({2'b00, entry_reg.y});
        rr       = signed'({8'b0, entry_reg.r});
        lo_x     = cx - rr;
        hi_x     = cx + rr;
        lo_y     = cy - rr;
        hi_y     = cy + rr;
        px0_c    = (lo_x < 0) ? 8'd0 : lo_x[7:0];
        py0_c    = (lo_y < 0) ? 8'd0 : lo_y[7:0];
        px1_c    = (hi_x > X_MAX) ? X_MAX[7:0] : hi_x[7:0];
        py1_c    = (hi_y > Y_MAX) ? Y_MAX[7:0] : hi_y[7:0];
        entry_ok = (entry_reg.x < X_LIM) && (entry_reg.y < Y_LIM);
    end

    // Row base is a sum of shifted WIDTH terms selected by the bits of py0.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_row
            assign row_part[gi] = py0_c[gi] ? (ADDR_W'(WIDTH) << gi) : '0;
        end
    endgenerate

    always_comb begin
        row_base_c = '0;
        for (int b = 0; b < 8; b++) begin
            row_base_c = row_base_c + row_part[b];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!fifo_empty) state_next = SETUP;
            SETUP:   state_next = entry_ok ? PAINT : IDLE;
            PAINT:   if (fbGrant && px_reg == px1_reg && py_reg == py1_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fbWe     = (state_reg == PAINT);
        fbAddr   = fbWe ? (row_base_reg + ADDR_W'(px_reg)) : '0;
        fbData   = fbWe ? entry_reg.color : 3'd0;
        busy     = (state_reg != IDLE) | ~fifo_empty;
        overflow = overflow_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            brush_q_reg  <= 1'b0;
            config_q_reg <= 1'b0;
            color_reg    <= COLOR_RST;
            size_reg     <= 2'd0;
            overflow_reg <= 1'b0;
            entry_reg    <= '0;
            px_reg       <= '0;
            py_reg       <= '0;
            px0_reg      <= '0;
            px1_reg      <= '0;
            py1_reg      <= '0;
            row_base_reg <= '0;
        end else begin
            brush_q_reg  <= brushUpdate;
            config_q_reg <= updateConfig;
            if (config_edge) begin
                color_reg <= newColorUpdate;
                size_reg  <= x[1:0];
            end
            if (brush_edge && fifo_full && !fifo_pop) begin
                overflow_reg <= 1'b1;
            end
            if (fifo_pop) begin
                entry_reg <= fifo_head;
            end
            if (state_reg == SETUP) begin
                px0_reg      <= px0_c;
                px1_reg      <= px1_c;
                py1_reg      <= py1_c;
                px_reg       <= px0_c;
                py_reg       <= py0_c;
                row_base_reg <= row_base_c;
            end else if (state_reg == PAINT && fbGrant) begin
                if (px_reg == px1_reg) begin
                    px_reg       <= px0_reg;
                    py_reg       <= py_reg + 8'd1;
                    row_base_reg <= row_base_reg + ADDR_W'(WIDTH);
                end else begin
                    px_reg <= px_reg + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_brush_painter.sv
// Directed bench for brush_painter: stamps, clipping, grant stalls, FIFO overflow,
// level/invalid commands and reset mid-stamp.
module tb_brush_painter;

    logic        clk = 1'b0;
    logic        reset;
    logic        brushUpdate;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [2:0]  newColorUpdate;
    logic        updateConfig;
    logic        fbGrant;
    logic        fbWe;
    logic [14:0] fbAddr;
    logic [2:0]  fbData;
    logic        busy;
    logic        overflow;

    int checks   = 0;
    int failures = 0;
    int wr_addr[$];
    int wr_data[$];

    brush_painter dut (
        .clk           (clk),
        .reset         (reset),
        .brushUpdate   (brushUpdate),
        .x             (x),
        .y             (y),
        .newColorUpdate(newColorUpdate),
        .updateConfig  (updateConfig),
        .fbGrant       (fbGrant),
        .fbWe          (fbWe),
        .fbAddr        (fbAddr),
        .fbData        (fbData),
        .busy          (busy),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Every committed write (request and grant both high) is logged in order.
    always @(negedge clk) begin
        if (fbWe === 1'b1 && fbGrant === 1'b1) begin
            wr_addr.push_back(int'(fbAddr));
            wr_data.push_back(int'(fbData));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic pulse_config(input logic [2:0] c, input logic [1:0] sz);
        newColorUpdate = c;
        x              = {6'd0, sz};
        updateConfig   = 1'b1;
        step(1);
        updateConfig   = 1'b0;
        step(1);
    endtask

    task automatic pulse_brush(input logic [7:0] bx, input logic [7:0] by);
        x           = bx;
        y           = by;
        brushUpdate = 1'b1;
        step(1);
        brushUpdate = 1'b0;
        step(1);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && fbWe === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        step(1);
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        brushUpdate    = 1'b0;
        updateConfig   = 1'b0;
        fbGrant        = 1'b0;
        x              = 8'd0;
        y              = 8'd0;
        newColorUpdate = 3'd0;
        step(3);
        checks++;
        if ({fbWe, fbAddr, fbData, busy, overflow} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs: got we=%0b addr=%0d data=%0d busy=%0b ovf=%0b required all 0",
                     fbWe, fbAddr, fbData, busy, overflow);
        end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_single_stamp();
        bit ok;
        int idx;
        pulse_config(3'b101, 2'd1);
        fbGrant = 1'b1;
        clear_log();
        pulse_brush(8'd10, 8'd20);
        wait_idle(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL stamp1_idle: got busy=%0b required 0 within budget", busy);
        end
        checks++;
        if (wr_addr.size() !== 9) begin
            failures++;
            $display("FAIL stamp1_count: got %0d required 9", wr_addr.size());
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                idx = r * 3 + c;
                checks++;
                if (wr_addr[idx] !== (19 + r) * 160 + 9 + c || wr_data[idx] !== 5) begin
                    failures++;
                    $display("FAIL stamp1_pix%0d: got addr=%0d data=%0d required addr=%0d data=5",
                             idx, wr_addr[idx], wr_data[idx], (19 + r) * 160 + 9 + c);
                end
            end
        end
        $display("stamp1 done: %0d writes", wr_addr.size());
    endtask

    task automatic test_clip_corner();
        bit ok;
        int exp_a[9] = '{0, 1, 2, 160, 161, 162, 320, 321, 322};
        pulse_config(3'b101, 2'd2);
        fbGrant = 1'b1;
        clear_log();
        pulse_brush(8'd0, 8'd0);
        wait_idle(ok);
        checks++;
        if (!ok || wr_addr.size() !== 9) begin
            failures++;
            $display("FAIL clip_count: got %0d writes idle=%0b required 9 idle=1", wr_addr.size(), ok);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (wr_addr[i] !== exp_a[i]) begin
                failures++;
                $display("FAIL clip_pix%0d: got addr=%0d required %0d", i, wr_addr[i], exp_a[i]);
            end
        end
        $display("clip corner done: %0d writes", wr_addr.size());
    endtask

    task automatic test_grant_stall();
        bit ok;
        int held;
        int idx;
        int guard;
        pulse_config(3'd6, 2'd1);
        fbGrant = 1'b1;
        clear_log();
        x           = 8'd50;
        y           = 8'd50;
        brushUpdate = 1'b1;
        step(1);
        brushUpdate = 1'b0;
        guard = 0;
        while (wr_addr.size() < 4 && guard < 50) begin
            step(1);
            guard++;
        end
        fbGrant = 1'b0;
        @(negedge clk);
        held = int'(fbAddr);
        checks++;
        if (held !== 50 * 160 + 50 || fbWe !== 1'b1) begin
            failures++;
            $display("FAIL stall_start: got addr=%0d we=%0b required addr=%0d we=1", held, fbWe, 50 * 160 + 50);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (int'(fbAddr) !== held || fbData !== 3'd6 || fbWe !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold%0d: got addr=%0d data=%0d we=%0b required addr=%0d data=6 we=1",
                         i, fbAddr, fbData, fbWe, held);
            end
        end
        step(1);
        fbGrant = 1'b1;
        wait_idle(ok);
        checks++;
        if (!ok || wr_addr.size() !== 9) begin
            failures++;
            $display("FAIL stall_count: got %0d writes idle=%0b required 9 idle=1", wr_addr.size(), ok);
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                idx = r * 3 + c;
                checks++;
                if (wr_addr[idx] !== (49 + r) * 160 + 49 + c) begin
                    failures++;
                    $display("FAIL stall_pix%0d: got addr=%0d required %0d",
                             idx, wr_addr[idx], (49 + r) * 160 + 49 + c);
                end
            end
        end
        $display("grant stall done: %0d writes", wr_addr.size());
    endtask

    task automatic test_overflow();
        bit ok;
        pulse_config(3'd2, 2'd0);
        fbGrant = 1'b0;
        clear_log();
        for (int i = 0; i < 6; i++) begin
            pulse_brush(8'(30 + i), 8'd40);
        end
        checks++;
        if (overflow !== 1'b1 || busy !== 1'b1 || fbWe !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flag: got ovf=%0b busy=%0b we=%0b required 1 1 1", overflow, busy, fbWe);
        end
        fbGrant = 1'b1;
        wait_idle(ok);
        checks++;
        if (!ok || wr_addr.size() !== 5) begin
            failures++;
            $display("FAIL ovf_count: got %0d writes idle=%0b required 5 idle=1", wr_addr.size(), ok);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (wr_addr[i] !== 6400 + 30 + i || wr_data[i] !== 2) begin
                failures++;
                $display("FAIL ovf_pix%0d: got addr=%0d data=%0d required addr=%0d data=2",
                         i, wr_addr[i], wr_data[i], 6430 + i);
            end
        end
        $display("overflow done: %0d writes ovf=%0b", wr_addr.size(), overflow);
    endtask

    task automatic test_level_and_invalid();
        bit ok;
        fbGrant = 1'b1;
        clear_log();
        x           = 8'd70;
        y           = 8'd10;
        brushUpdate = 1'b1;
        step(10);
        brushUpdate = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok || wr_addr.size() !== 1 || wr_addr[0] !== 10 * 160 + 70) begin
            failures++;
            $display("FAIL level_once: got %0d writes first=%0d required 1 write at %0d",
                     wr_addr.size(), wr_addr[0], 10 * 160 + 70);
        end
        clear_log();
        pulse_brush(8'd200, 8'd5);
        wait_idle(ok);
        checks++;
        if (!ok || wr_addr.size() !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL invalid_x: got %0d writes busy=%0b required 0 writes busy=0", wr_addr.size(), busy);
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky: got %0b required 1", overflow);
        end
        $display("level/invalid done");
    endtask

    task automatic test_reset_mid_stamp();
        bit ok;
        int guard;
        pulse_config(3'd3, 2'd3);
        fbGrant = 1'b1;
        clear_log();
        x           = 8'd60;
        y           = 8'd60;
        brushUpdate = 1'b1;
        step(1);
        brushUpdate = 1'b0;
        guard = 0;
        while (wr_addr.size() < 5 && guard < 50) begin
            step(1);
            guard++;
        end
        reset = 1'b1;
        step(1);
        checks++;
        if (fbWe !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got we=%0b ovf=%0b busy=%0b required 0 0 0", fbWe, overflow, busy);
        end
        reset = 1'b0;
        clear_log();
        step(20);
        checks++;
        if (wr_addr.size() !== 0) begin
            failures++;
            $display("FAIL reset_quiet: got %0d writes required 0", wr_addr.size());
        end
        pulse_brush(8'd5, 8'd5);
        wait_idle(ok);
        checks++;
        if (!ok || wr_addr.size() !== 1 || wr_addr[0] !== 805 || wr_data[0] !== 7) begin
            failures++;
            $display("FAIL reset_defaults: got %0d writes addr=%0d data=%0d required 1 write addr=805 data=7",
                     wr_addr.size(), wr_addr[0], wr_data[0]);
        end
        $display("reset mid-stamp done");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_stamp();
        test_clip_corner();
        test_grant_stall();
        test_overflow();
        test_level_and_invalid();
        test_reset_mid_stamp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
